issue_stage: RTL

- Dispatch stage of the out-of-order core. It takes one decoded instruction at a time from the decoder and resolves its source operands through the register-status file, the ROB and the CDB.
- It allocates the ROB tail entry and transmits the instruction on the shared issue bus to the RS (ALU ops) or the LSB (loads/stores).
- It is the sending side of the RS issue port; the RS only latches what this block drives.

---
 rtl/issue_stage_if.sv | 59 +++++
 rtl/issue_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/issue_stage_if.sv
// Bundle between the dispatch stage and its neighbours: decoder, register status,
// ROB, result buses (CDB) and the shared RS/LSB issue bus.
interface issue_stage_if #(parameter int ROB_POS_W = 4);
  logic                 rdy, rollback;
  logic                 dec_valid, dec_ready;
  logic [6:0]           dec_opcode;
  logic [2:0]           dec_funct3;
  logic                 dec_funct7;
  logic [4:0]           dec_rd, dec_rs1, dec_rs2;
  logic [31:0]          dec_imm, dec_pc;
  logic [4:0]           rf_rs1_idx, rf_rs2_idx;
  logic [31:0]          rf_rs1_val, rf_rs2_val;
  logic                 rf_rs1_busy, rf_rs2_busy;
  logic [ROB_POS_W-1:0] rf_rs1_rob_pos, rf_rs2_rob_pos;
  logic [ROB_POS_W-1:0] rob_q1_pos, rob_q2_pos;
  logic                 rob_q1_ready, rob_q2_ready;
  logic [31:0]          rob_q1_val, rob_q2_val;
  logic                 rob_full;
  logic [ROB_POS_W-1:0] rob_free_pos;
  logic                 rs_nxt_full, lsb_nxt_full;
  logic                 alu_result, lsb_result;
  logic [31:0]          alu_result_val, lsb_result_val;
  logic [ROB_POS_W-1:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic                 issue_rob, issue_rs, issue_lsb;
  logic [6:0]           issue_opcode;
  logic [2:0]           issue_funct3;
  logic                 issue_funct7;
  logic [4:0]           issue_rd;
  logic [31:0]          issue_imm, issue_pc, issue_rs1_val, issue_rs2_val;
  logic [ROB_POS_W:0]   issue_rs1_rob_id, issue_rs2_rob_id;
  logic [ROB_POS_W-1:0] issue_rob_pos;
  logic                 rename_en;
  logic [4:0]           rename_rd;
  logic [ROB_POS_W-1:0] rename_rob_pos;

  modport master (
    input  rdy, rollback, dec_valid, dec_opcode, dec_funct3, dec_funct7, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_pc, rf_rs1_val, rf_rs2_val, rf_rs1_busy, rf_rs2_busy,
           rf_rs1_rob_pos, rf_rs2_rob_pos, rob_q1_ready, rob_q2_ready, rob_q1_val, rob_q2_val,
           rob_full, rob_free_pos, rs_nxt_full, lsb_nxt_full, alu_result, alu_result_val,
           alu_result_rob_pos, lsb_result, lsb_result_val, lsb_result_rob_pos,
    output dec_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_pos, rob_q2_pos, issue_rob, issue_rs,
           issue_lsb, issue_opcode, issue_funct3, issue_funct7, issue_rd, issue_imm, issue_pc,
           issue_rs1_val, issue_rs2_val, issue_rs1_rob_id, issue_rs2_rob_id, issue_rob_pos,
           rename_en, rename_rd, rename_rob_pos
  );

  modport slave (
    output rdy, rollback, dec_valid, dec_opcode, dec_funct3, dec_funct7, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_pc, rf_rs1_val, rf_rs2_val, rf_rs1_busy, rf_rs2_busy,
           rf_rs1_rob_pos, rf_rs2_rob_pos, rob_q1_ready, rob_q2_ready, rob_q1_val, rob_q2_val,
           rob_full, rob_free_pos, rs_nxt_full, lsb_nxt_full, alu_result, alu_result_val,
           alu_result_rob_pos, lsb_result, lsb_result_val, lsb_result_rob_pos,
    input  dec_ready, rf_rs1_idx, rf_rs2_idx, rob_q1_pos, rob_q2_pos, issue_rob, issue_rs,
           issue_lsb, issue_opcode, issue_funct3, issue_funct7, issue_rd, issue_imm, issue_pc,
           issue_rs1_val, issue_rs2_val, issue_rs1_rob_id, issue_rs2_rob_id, issue_rob_pos,
           rename_en, rename_rd, rename_rob_pos
  );
endinterface

// File: rtl/issue_stage.sv
// Dispatch stage: holds one decoded instruction, resolves its operands through
// register status / CDB / ROB and sends it to the RS or LSB with a ROB allocation.
module issue_stage #(
  parameter int ROB_POS_W = 4
) (
  input logic           clk,
  input logic           rst,
  issue_stage_if.master bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int TAG_W = ROB_POS_W + 1;
  localparam int RES_W = TAG_W + 32;

  // Returns {tag, value}; the CDB is checked before the ROB so a result broadcast
  // in the same cycle as the RS entry write is not lost.
  function automatic logic [RES_W-1:0] resolve(
    input logic used, input logic [4:0] idx, input logic busy, input logic [31:0] rf_val,
    input logic [ROB_POS_W-1:0] pos,
    input logic alu_v, input logic [31:0] alu_val, input logic [ROB_POS_W-1:0] alu_pos,
    input logic lsb_v, input logic [31:0] lsb_val, input logic [ROB_POS_W-1:0] lsb_pos,
    input logic rob_rdy, input logic [31:0] rob_val);
    logic [RES_W-1:0] res;
    if (!used || idx == 5'd0)           res = '0;
    else if (!busy)                     res = {{TAG_W{1'b0}}, rf_val};
    else if (alu_v && alu_pos == pos)   res = {{TAG_W{1'b0}}, alu_val};
    else if (lsb_v && lsb_pos == pos)   res = {{TAG_W{1'b0}}, lsb_val};
    else if (rob_rdy)                   res = {{TAG_W{1'b0}}, rob_val};
    else                                res = {1'b1, pos, 32'd0};
    return res;
  endfunction

  logic                 r_hold_valid;
  logic [6:0]           r_opcode;
  logic [2:0]           r_funct3;
  logic                 r_funct7;
  logic [4:0]           r_rd, r_rs1, r_rs2;
  logic [31:0]          r_imm, r_pc;
  logic                 r_issue_rob, r_issue_rs, r_issue_lsb, r_rename_en;
  logic [6:0]           r_issue_opcode;
  logic [2:0]           r_issue_funct3;
  logic                 r_issue_funct7;
  logic [4:0]           r_issue_rd, r_rename_rd;
  logic [31:0]          r_issue_imm, r_issue_pc, r_rs1_val, r_rs2_val;
  logic [TAG_W-1:0]     r_rs1_rob_id, r_rs2_rob_id;
  logic [ROB_POS_W-1:0] r_issue_rob_pos, r_rename_rob_pos;

  logic                 w_is_mem, w_use_rs1, w_use_rs2, w_writes_rd;
  logic                 w_fire, w_dec_ready, w_capture;
  logic [RES_W-1:0]     w_src1, w_src2;

  // Instruction classification, fire/accept handshake and operand resolution.
  always_comb begin
    w_is_mem    = (r_opcode == OP_LOAD) || (r_opcode == OP_STORE);
    w_use_rs1   = !((r_opcode == OP_LUI) || (r_opcode == OP_AUIPC) || (r_opcode == OP_JAL));
    w_use_rs2   = (r_opcode == OP_REG) || (r_opcode == OP_STORE) || (r_opcode == OP_BRANCH);
    w_writes_rd = (r_rd != 5'd0) && (r_opcode != OP_STORE) && (r_opcode != OP_BRANCH);
    w_fire      = bus.rdy && !bus.rollback && r_hold_valid && !bus.rob_full &&
                  (w_is_mem ? !bus.lsb_nxt_full : !bus.rs_nxt_full);
    w_dec_ready = !bus.rollback && (!r_hold_valid || w_fire);
    w_capture   = bus.rdy && bus.dec_valid && w_dec_ready;
    w_src1 = resolve(w_use_rs1, r_rs1, bus.rf_rs1_busy, bus.rf_rs1_val, bus.rf_rs1_rob_pos,
                     bus.alu_result, bus.alu_result_val, bus.alu_result_rob_pos,
                     bus.lsb_result, bus.lsb_result_val, bus.lsb_result_rob_pos,
                     bus.rob_q1_ready, bus.rob_q1_val);
    w_src2 = resolve(w_use_rs2, r_rs2, bus.rf_rs2_busy, bus.rf_rs2_val, bus.rf_rs2_rob_pos,
                     bus.alu_result, bus.alu_result_val, bus.alu_result_rob_pos,
                     bus.lsb_result, bus.lsb_result_val, bus.lsb_result_rob_pos,
                     bus.rob_q2_ready, bus.rob_q2_val);
  end

  // Hold register and registered issue/rename outputs; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_opcode <= 7'd0; r_funct3 <= 3'd0; r_funct7 <= 1'b0;
      r_rd <= 5'd0; r_rs1 <= 5'd0; r_rs2 <= 5'd0; r_imm <= 32'd0; r_pc <= 32'd0;
      r_issue_rob <= 1'b0; r_issue_rs <= 1'b0; r_issue_lsb <= 1'b0; r_rename_en <= 1'b0;
      r_issue_opcode <= 7'd0; r_issue_funct3 <= 3'd0; r_issue_funct7 <= 1'b0;
      r_issue_rd <= 5'd0; r_rename_rd <= 5'd0;
      r_issue_imm <= 32'd0; r_issue_pc <= 32'd0; r_rs1_val <= 32'd0; r_rs2_val <= 32'd0;
      r_rs1_rob_id <= '0; r_rs2_rob_id <= '0;
      r_issue_rob_pos <= '0; r_rename_rob_pos <= '0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        r_hold_valid <= 1'b0;
        r_issue_rob  <= 1'b0;
        r_issue_rs   <= 1'b0;
        r_issue_lsb  <= 1'b0;
        r_rename_en  <= 1'b0;
      end else begin
        r_issue_rob <= w_fire;
        r_issue_rs  <= w_fire && !w_is_mem;
        r_issue_lsb <= w_fire && w_is_mem;
        r_rename_en <= w_fire && w_writes_rd;
        if (w_fire) begin
          r_issue_opcode   <= r_opcode;
          r_issue_funct3   <= r_funct3;
          r_issue_funct7   <= r_funct7;
          r_issue_rd       <= r_rd;
          r_issue_imm      <= r_imm;
          r_issue_pc       <= r_pc;
          r_rs1_val        <= w_src1[31:0];
          r_rs1_rob_id     <= w_src1[RES_W-1:32];
          r_rs2_val        <= w_src2[31:0];
          r_rs2_rob_id     <= w_src2[RES_W-1:32];
          r_issue_rob_pos  <= bus.rob_free_pos;
          r_rename_rd      <= r_rd;
          r_rename_rob_pos <= bus.rob_free_pos;
        end
        if (w_capture) begin
          r_hold_valid <= 1'b1;
          r_opcode <= bus.dec_opcode; r_funct3 <= bus.dec_funct3; r_funct7 <= bus.dec_funct7;
          r_rd <= bus.dec_rd; r_rs1 <= bus.dec_rs1; r_rs2 <= bus.dec_rs2;
          r_imm <= bus.dec_imm; r_pc <= bus.dec_pc;
        end else if (w_fire) begin
          r_hold_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.dec_ready        = w_dec_ready;
  assign bus.rf_rs1_idx       = r_rs1;
  assign bus.rf_rs2_idx       = r_rs2;
  assign bus.rob_q1_pos       = bus.rf_rs1_rob_pos;
  assign bus.rob_q2_pos       = bus.rf_rs2_rob_pos;
  assign bus.issue_rob        = r_issue_rob;
  assign bus.issue_rs         = r_issue_rs;
  assign bus.issue_lsb        = r_issue_lsb;
  assign bus.issue_opcode     = r_issue_opcode;
  assign bus.issue_funct3     = r_issue_funct3;
  assign bus.issue_funct7     = r_issue_funct7;
  assign bus.issue_rd         = r_issue_rd;
  assign bus.issue_imm        = r_issue_imm;
  assign bus.issue_pc         = r_issue_pc;
  assign bus.issue_rs1_val    = r_rs1_val;
  assign bus.issue_rs2_val    = r_rs2_val;
  assign bus.issue_rs1_rob_id = r_rs1_rob_id;
  assign bus.issue_rs2_rob_id = r_rs2_rob_id;
  assign bus.issue_rob_pos    = r_issue_rob_pos;
  assign bus.rename_en        = r_rename_en;
  assign bus.rename_rd        = r_rename_rd;
  assign bus.rename_rob_pos   = r_rename_rob_pos;
endmodule
